// File: rtl/fp_convert_unit.sv
// fp_convert_unit: multi-cycle float/int conversion (demote, promote, int->float) with RNE; FPCVT_CANON_NAN_EN makes NaN results canonical
module fp_convert_unit #(
    parameter bit USE_64B   = 1,
    parameter int NORM_STEP = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  mode,
    input  logic [63:0] operand,
    output logic        ready,
    output logic        done,
    output logic [63:0] result,
    output logic [1:0]  result_type,
    output logic [3:0]  trap
);
    localparam logic [1:0] T_F32 = 2'd0, T_F64 = 2'd1;
    localparam logic [3:0] NO_64B = 4'h1, BAD_MODE = 4'hF;
    localparam logic [1:0] C_NUM = 2'd0, C_ZERO = 2'd1, C_INF = 2'd2, C_NAN = 2'd3;
`ifdef FPCVT_CANON_NAN_EN
    localparam bit CANON = 1'b1;
`else
    localparam bit CANON = 1'b0;
`endif
    typedef enum logic [2:0] {IDLE, UNPACK, NORM, ROUND, DONE} state_t;
    state_t state, nxt;
    logic [3:0] mode_q, trap_q;
    logic [63:0] op_q, mant, u_mant, mag, res_q, r_val, num, inf_v, nan_v, zero_v;
    logic signed [13:0] exp_q, u_exp;
    logic [1:0] cls, u_cls;
    logic sgn, u_sgn, is_dem, is_pro, i64, sgnd, to64, trap64, need_norm;
    logic [6:0] lz, nsh;
    logic signed [15:0] e16, emin, bias, t, be;
    logic [116:0] ext;
    logic [52:0] kept;
    logic [53:0] sig;
    logic far, g, st, rnd, den, carry, hid, ovf;
    function automatic logic [6:0] lzc(input logic [63:0] v);
        lzc = 7'd64;
        for (int i = 0; i < 64; i++) if (v[i]) lzc = 7'(63 - i);
    endfunction
    assign is_dem = mode_q == 4'd0;
    assign is_pro = mode_q == 4'd1;
    assign i64 = mode_q inside {4'd4, 4'd5, 4'd8, 4'd9};
    assign sgnd = mode_q inside {4'd2, 4'd4, 4'd6, 4'd8};
    assign to64 = is_pro || (mode_q >= 4'd6 && mode_q <= 4'd9);
    assign trap64 = !USE_64B && !(mode_q == 4'd2 || mode_q == 4'd3);
    assign lz = lzc(mant);
    assign nsh = (lz < 7'(NORM_STEP)) ? lz : 7'(NORM_STEP);
    // state register
    always_ff @(posedge clk) state <= reset ? IDLE : nxt;
    // next-state and ready
    always_comb begin
        nxt = state;
        ready = state == IDLE;
        case (state)
            IDLE:    if (start) nxt = (mode > 4'd9) ? DONE : UNPACK;
            UNPACK:  nxt = trap64 ? DONE : (need_norm ? NORM : ROUND);
            NORM:    nxt = (lz <= 7'(NORM_STEP)) ? ROUND : NORM;
            ROUND:   nxt = DONE;
            DONE:    nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end
    // split the latched operand into sign / unbiased exponent / MSB-aligned mantissa
    always_comb begin
        u_sgn = 1'b0;
        u_exp = '0;
        u_mant = '0;
        u_cls = C_NUM;
        mag = '0;
        if (is_dem) begin
            u_sgn = op_q[63];
            u_exp = (op_q[62:52] == 11'd0) ? -14'sd1022 : $signed({3'b0, op_q[62:52]}) - 14'sd1023;
            u_mant = {op_q[62:52] != 11'd0, op_q[51:0], 11'b0};
            u_cls = (op_q[62:52] == 11'h7FF) ? ((op_q[51:0] == 52'd0) ? C_INF : C_NAN) : ((op_q[62:0] == 63'd0) ? C_ZERO : C_NUM);
        end else if (is_pro) begin
            u_sgn = op_q[31];
            u_exp = (op_q[30:23] == 8'd0) ? -14'sd126 : $signed({6'b0, op_q[30:23]}) - 14'sd127;
            u_mant = {op_q[30:23] != 8'd0, op_q[22:0], 40'b0};
            u_cls = (op_q[30:23] == 8'hFF) ? ((op_q[22:0] == 23'd0) ? C_INF : C_NAN) : ((op_q[30:0] == 31'd0) ? C_ZERO : C_NUM);
        end else begin
            u_sgn = sgnd && (i64 ? op_q[63] : op_q[31]);
            mag = i64 ? (u_sgn ? -op_q : op_q) : {32'b0, u_sgn ? -op_q[31:0] : op_q[31:0]};
            u_exp = i64 ? 14'sd63 : 14'sd31;
            u_mant = i64 ? mag : {mag[31:0], 32'b0};
            u_cls = (mag == 64'd0) ? C_ZERO : C_NUM;
        end
        need_norm = u_cls == C_NUM && !u_mant[63] && !is_dem;
    end
    // round-to-nearest-even into the target format, denormalising below the minimum exponent
    always_comb begin
        e16 = {{2{exp_q[13]}}, exp_q};
        emin = to64 ? -16'sd1022 : -16'sd126;
        bias = to64 ? 16'sd1023 : 16'sd127;
        den = e16 < emin;
        t = (to64 ? 16'sd0 : 16'sd29) + (den ? emin - e16 : 16'sd0);
        far = t > 16'sd53;
        ext = {mant, 53'b0} >> t[6:0];
        kept = far ? 53'd0 : ext[116:64];
        g = !far && ext[63];
        st = far ? |mant : |ext[62:0];
        rnd = g && (st || kept[0]);
        sig = {1'b0, kept} + {53'b0, rnd};
        carry = to64 ? sig[53] : sig[24];
        hid = to64 ? sig[52] : sig[23];
        be = den ? {15'b0, hid} : e16 + bias + {15'b0, carry};
        ovf = !den && be >= (to64 ? 16'sd2047 : 16'sd255);
        num = to64 ? {sgn, be[10:0], sig[51:0]} : {32'b0, sgn, be[7:0], sig[22:0]};
        inf_v = to64 ? {sgn, 11'h7FF, 52'b0} : {32'b0, sgn, 8'hFF, 23'b0};
        nan_v = to64 ? {sgn, 11'h7FF, 1'b1, CANON ? 51'b0 : {op_q[21:0], 29'b0}} : {32'b0, sgn, 8'hFF, 1'b1, CANON ? 22'b0 : op_q[50:29]};
        zero_v = to64 ? {sgn, 63'b0} : {32'b0, sgn, 31'b0};
        r_val = (cls == C_ZERO) ? zero_v : (cls == C_NAN) ? nan_v : (cls == C_INF || ovf) ? inf_v : num;
    end
    // datapath registers and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            done <= 1'b0;
            result <= '0;
            result_type <= T_F32;
            trap <= '0;
            trap_q <= '0;
            res_q <= '0;
            mode_q <= '0;
            op_q <= '0;
            sgn <= 1'b0;
            exp_q <= '0;
            mant <= '0;
            cls <= C_NUM;
        end else begin
            done <= state == DONE;
            if (state == IDLE && start) begin
                mode_q <= mode;
                op_q <= operand;
                trap_q <= (mode > 4'd9) ? BAD_MODE : 4'h0;
                res_q <= '0;
            end
            if (state == UNPACK) begin
                sgn <= u_sgn;
                exp_q <= u_exp;
                mant <= u_mant;
                cls <= u_cls;
                if (trap64) trap_q <= NO_64B;
            end
            if (state == NORM) begin
                mant <= mant << nsh;
                exp_q <= exp_q - 14'(nsh);
            end
            if (state == ROUND) res_q <= r_val;
            if (state == DONE) begin
                result <= res_q;
                result_type <= to64 ? T_F64 : T_F32;
                trap <= trap_q;
            end
        end
    end
endmodule

// File: tb/tb_fp_convert_unit.sv
// tb_fp_convert_unit: directed and randomized checks of fp_convert_unit against an arithmetic reference model
module tb_fp_convert_unit;
    localparam int STEP = 4;
    logic clk = 1'b0, reset = 1'b1, start = 1'b0, start0 = 1'b0;
    logic [3:0] mode = '0;
    logic [63:0] operand = '0;
    logic ready, done, ready0, done0;
    logic [63:0] result, result0;
    logic [1:0] result_type, result_type0;
    logic [3:0] trap, trap0;
    int total = 0, bad = 0;
    always #5 clk = ~clk;
    fp_convert_unit #(.USE_64B(1), .NORM_STEP(STEP)) dut (
        .clk(clk), .reset(reset), .start(start), .mode(mode), .operand(operand),
        .ready(ready), .done(done), .result(result), .result_type(result_type), .trap(trap)
    );
    fp_convert_unit #(.USE_64B(0), .NORM_STEP(STEP)) dut0 (
        .clk(clk), .reset(reset), .start(start0), .mode(mode), .operand(operand),
        .ready(ready0), .done(done0), .result(result0), .result_type(result_type0), .trap(trap0)
    );
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask
    // value = mag * 2^e2, rounded to nearest even in f32 or f64
    function automatic logic [63:0] enc(input bit s, input logic [63:0] mag, input int e2, input bit f64);
        int p, bias, e, d, msb, be;
        logic [127:0] m, keep, rem, half;
        logic [63:0] frac;
        p = f64 ? 52 : 23;
        bias = f64 ? 1023 : 127;
        if (mag == 64'd0) return f64 ? {s, 63'b0} : {32'b0, s, 31'b0};
        msb = 0;
        for (int i = 0; i < 64; i++) if (mag[i]) msb = i;
        e = msb + e2;
        if (e < 1 - bias) e = 1 - bias;
        d = e - p - e2;
        m = {64'b0, mag};
        if (d <= 0) keep = m << (-d);
        else if (d > 128) keep = '0;
        else begin
            keep = m >> d;
            rem = m - (keep << d);
            half = 128'd1 << (d - 1);
            if (rem > half || (rem == half && keep[0])) keep = keep + 128'd1;
        end
        if ((keep >> (p + 1)) != 128'd0) begin
            keep = keep >> 1;
            e++;
        end
        be = ((keep >> p) == 128'd0) ? 0 : e + bias;
        if (be >= (f64 ? 2047 : 255)) return f64 ? {s, 11'h7FF, 52'b0} : {32'b0, s, 8'hFF, 23'b0};
        frac = keep[63:0] & ((64'd1 << p) - 64'd1);
        return f64 ? {s, be[10:0], frac[51:0]} : {32'b0, s, be[7:0], frac[22:0]};
    endfunction
    function automatic logic [63:0] int_mag(input logic [3:0] m, input logic [63:0] op);
        bit w64, neg;
        logic [63:0] v;
        w64 = m inside {4'd4, 4'd5, 4'd8, 4'd9};
        v = w64 ? op : {32'b0, op[31:0]};
        neg = (m inside {4'd2, 4'd4, 4'd6, 4'd8}) && (w64 ? op[63] : op[31]);
        return neg ? (w64 ? ~op + 64'd1 : ((~v + 64'd1) & 64'hFFFF_FFFF)) : v;
    endfunction
    // {trap, result_type, result}
    function automatic logic [69:0] model(input logic [3:0] m, input logic [63:0] op, input bit use64);
        bit f64t, canon, neg;
`ifdef FPCVT_CANON_NAN_EN
        canon = 1'b1;
`else
        canon = 1'b0;
`endif
        if (m > 4'd9) return {4'hF, 2'd0, 64'd0};
        f64t = m == 4'd1 || m >= 4'd6;
        if (!use64 && !(m == 4'd2 || m == 4'd3)) return {4'h1, f64t ? 2'd1 : 2'd0, 64'd0};
        if (m == 4'd0) begin
            if (op[62:52] == 11'h7FF)
                return {6'd0, op[51:0] == 52'd0 ? {32'b0, op[63], 8'hFF, 23'b0} : {32'b0, op[63], 8'hFF, 1'b1, canon ? 22'b0 : op[50:29]}};
            return {6'd0, enc(op[63], (op[62:52] != 0) ? {11'b0, 1'b1, op[51:0]} : {12'b0, op[51:0]}, ((op[62:52] != 0) ? int'(op[62:52]) : 1) - 1075, 1'b0)};
        end
        if (m == 4'd1) begin
            if (op[30:23] == 8'hFF)
                return {6'd1, op[22:0] == 23'd0 ? {op[31], 11'h7FF, 52'b0} : {op[31], 11'h7FF, 1'b1, canon ? 51'b0 : {op[21:0], 29'b0}}};
            return {6'd1, enc(op[31], (op[30:23] != 0) ? {40'b0, 1'b1, op[22:0]} : {41'b0, op[22:0]}, ((op[30:23] != 0) ? int'(op[30:23]) : 1) - 150, 1'b1)};
        end
        neg = (m inside {4'd2, 4'd4, 4'd6, 4'd8}) && ((m inside {4'd4, 4'd8}) ? op[63] : op[31]);
        return {4'd0, f64t ? 2'd1 : 2'd0, enc(neg, int_mag(m, op), 0, f64t)};
    endfunction
    function automatic int exp_lat(input logic [3:0] m, input logic [63:0] op, input bit use64);
        int lz, msb;
        logic [63:0] v;
        if (!use64 && !(m == 4'd2 || m == 4'd3)) return 2;
        lz = 0;
        if (m == 4'd1 && op[30:23] == 8'd0 && op[22:0] != 23'd0) begin
            msb = 0;
            for (int i = 0; i < 23; i++) if (op[i]) msb = i;
            lz = 23 - msb;
        end else if (m >= 4'd2) begin
            v = int_mag(m, op);
            if (v != 64'd0) begin
                msb = 0;
                for (int i = 0; i < 64; i++) if (v[i]) msb = i;
                lz = ((m inside {4'd4, 4'd5, 4'd8, 4'd9}) ? 63 : 31) - msb;
            end
        end
        return 3 + (lz + STEP - 1) / STEP;
    endfunction
    task automatic do_op(input logic [3:0] m, input logic [63:0] op, input bit on0, output int lat);
        @(negedge clk);
        mode = m;
        operand = op;
        if (on0) start0 = 1'b1; else start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        start0 = 1'b0;
        lat = 0;
        while (lat < 200) begin
            @(posedge clk);
            lat++;
            #1;
            if (on0 ? done0 : done) break;
        end
    endtask
    task automatic op_check(input string tag, input bit on0, input logic [3:0] m, input logic [63:0] op,
                            input logic [63:0] er, input logic [1:0] ert, input logic [3:0] etr, input int elat);
        int lat;
        do_op(m, op, on0, lat);
        check({tag, " lat"}, 64'(lat), 64'(elat));
        check({tag, " res"}, on0 ? result0 : result, er);
        check({tag, " type"}, 64'(on0 ? result_type0 : result_type), 64'(ert));
        check({tag, " trap"}, 64'(on0 ? trap0 : trap), 64'(etr));
    endtask
    initial begin
        logic [69:0] exp_v;
        logic [63:0] op;
        logic [3:0] m;
        int lat, seen;
        bit on0;
        repeat (3) @(posedge clk);
        #1;
        check("rst ready", 64'(ready), 64'd1);
        check("rst done", 64'(done), 64'd0);
        check("rst result", result, 64'd0);
        check("rst type", 64'(result_type), 64'd0);
        check("rst trap", 64'(trap), 64'd0);
        check("rst0 ready", 64'(ready0), 64'd1);
        @(negedge clk) reset = 1'b0;
        op_check("demote -2", 0, 4'd0, 64'hC000_0000_0000_0000, 64'h0000_0000_C000_0000, 2'd0, 4'd0, 3);
        op_check("promote 1.5", 0, 4'd1, 64'h3FC0_0000, 64'h3FF8_0000_0000_0000, 2'd1, 4'd0, 3);
        op_check("promote sub", 0, 4'd1, 64'h0000_0001, 64'h36A0_0000_0000_0000, 2'd1, 4'd0, 3 + (23 + STEP - 1) / STEP);
        op_check("i32_s -1", 0, 4'd2, 64'hFFFF_FFFF, 64'hBF80_0000, 2'd0, 4'd0, 3 + (31 + STEP - 1) / STEP);
        op_check("i64_u max", 0, 4'd5, 64'hFFFF_FFFF_FFFF_FFFF, 64'h5F80_0000, 2'd0, 4'd0, 3);
        op_check("i32_u tie", 0, 4'd3, 64'h0100_0001, 64'h4B80_0000, 2'd0, 4'd0, 3 + (7 + STEP - 1) / STEP);
        op_check("demote ovf", 0, 4'd0, 64'h7E37_E43C_8800_759C, 64'h7F80_0000, 2'd0, 4'd0, 3);
`ifdef FPCVT_CANON_NAN_EN
        op_check("demote nan", 0, 4'd0, 64'h7FF4_0000_0000_0000, 64'h7FC0_0000, 2'd0, 4'd0, 3);
`else
        op_check("demote nan", 0, 4'd0, 64'h7FF4_0000_0000_0000, 64'h7FE0_0000, 2'd0, 4'd0, 3);
`endif
        op_check("i64_s zero", 0, 4'd8, 64'd0, 64'd0, 2'd1, 4'd0, 3);
        op_check("no64 demote", 1, 4'd0, 64'hC000_0000_0000_0000, 64'd0, 2'd0, 4'h1, 2);
        op_check("no64 i32_s 5", 1, 4'd2, 64'd5, 64'h40A0_0000, 2'd0, 4'd0, 3 + (29 + STEP - 1) / STEP);
        do_op(4'hC, 64'h1234, 0, lat);
        check("bad mode done", 64'(lat < 200), 64'd1);
        check("bad mode trap", 64'(trap), 64'hF);
        check("bad mode res", result, 64'd0);
        // reset while normalising
        @(negedge clk);
        mode = 4'd1;
        operand = 64'd1;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk) reset = 1'b1;
        @(posedge clk);
        #1;
        check("mid rst done", 64'(done), 64'd0);
        check("mid rst result", result, 64'd0);
        @(negedge clk) reset = 1'b0;
        @(posedge clk);
        #1 check("mid rst ready", 64'(ready), 64'd1);
        seen = 0;
        repeat (12) begin
            @(posedge clk);
            #1 if (done) seen++;
        end
        check("mid rst no done", 64'(seen), 64'd0);
        // start held high while busy and through the DONE cycle
        @(negedge clk);
        mode = 4'd0;
        operand = 64'hC000_0000_0000_0000;
        start = 1'b1;
        @(posedge clk);
        #1 mode = 4'd1;
        operand = 64'h3FC0_0000;
        repeat (3) @(posedge clk);
        #1;
        check("busy done", 64'(done), 64'd1);
        check("busy res", result, 64'h0000_0000_C000_0000);
        @(negedge clk) start = 1'b0;
        @(posedge clk);
        #1;
        check("busy no 2nd done", 64'(done), 64'd0);
        check("busy ready", 64'(ready), 64'd1);
        for (int k = 0; k < 200; k++) begin
            m = 4'($urandom_range(0, 9));
            op = {$urandom, $urandom};
            case ($urandom_range(0, 5))
                0: op = op >> $urandom_range(0, 63);
                1: begin
                    op[62:52] = $urandom_range(0, 1) ? 11'h7FF : 11'h000;
                    op[30:23] = $urandom_range(0, 1) ? 8'hFF : 8'h00;
                    if ($urandom_range(0, 2) == 0) begin
                        op[51:0] = '0;
                        op[22:0] = '0;
                    end
                end
                2: op[62:52] = 11'($urandom_range(1023 - 160, 1023 + 130));
                3: begin
                    op[30:23] = 8'd0;
                    op[22:0] = op[22:0] >> $urandom_range(0, 22);
                end
                default: ;
            endcase
            on0 = (k % 5) == 0;
            exp_v = model(m, op, !on0);
            op_check($sformatf("rand%0d m%0d op%h", k, m, op), on0, m, op, exp_v[63:0], exp_v[65:64], exp_v[69:66], exp_lat(m, op, !on0));
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
